color_pipe: RTL and testbench
=============================

Name: color_pipe

Overview:
Parametrised, pipelined successor to the combinational pixel colour mapper in the score-display video path. Maps a per-pixel type tag plus instrument ID to RGB through a run-time-programmable palette. Adds cursor blinking, dimming of non-active instruments, and valid tracking. Sits between the pixel classifier and the video output serialiser; it is a pure streaming block with no backpressure.

Parameters:
NUM_INSTR, 4, number of instrument colour entries (1..16)
INSTR_W, 2, width of instrument_type and active_instr; must satisfy 2**INSTR_W >= NUM_INSTR
CW, 8, bits per colour channel
BLINK_PERIOD, 30, frames per blink half-period (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  pixel tag valid this cycle
pixel_type  in  6  tag: bits[3:0] staff lines, bit4 note, bit5 cursor
instrument_type  in  INSTR_W  instrument of a note pixel
frame_start  in  1  one-cycle pulse at start of each frame
blink_en  in  1  enable cursor blinking
highlight_en  in  1  enable dimming of non-active instruments
active_instr  in  INSTR_W  instrument kept at full brightness
pal_we  in  1  palette write strobe
pal_addr  in  PAL_AW  palette index; PAL_AW = clog2(NUM_INSTR+3)
pal_data  in  3*CW  {r,g,b} write data
out_valid  out  1  r/g/b valid
r, g, b  out  CW each  output colour
blink_phase  out  1  current blink phase (1 = cursor hidden)

Behaviour:
- Reset (rst_n low, async): out_valid=0, r=g=b=0, blink_phase=0, frame counter=0, pipeline valids=0, palette restored to defaults.
- Palette: NUM_INSTR+3 entries. Index i<NUM_INSTR = instrument i; NUM_INSTR = STAFF; NUM_INSTR+1 = CURSOR; NUM_INSTR+2 = BG.
- Palette defaults (all-ones channel = F, zero = 0): instr (i mod 4): 0 red F,0,0; 1 green 0,F,0; 2 blue 0,0,F; 3 yellow F,F,0. STAFF white F,F,F; CURSOR cyan 0,F,F; BG black 0,0,0.
- Palette writes:
  - Occur on the rising edge with pal_we=1.
  - pal_addr >= NUM_INSTR+3 is ignored.
  - A read in the same cycle as a write to the same entry returns the old value; the new value applies from the next cycle.
- Stage 1 (registered), decode by priority, highest wins:
  - bit5 -> CURSOR.
  - else bit4 -> instrument_type, but BG if instrument_type >= NUM_INSTR.
  - else any of bits[3:0] -> STAFF.
  - else (all zero) -> BG.
  - Registers the palette colour, class (cursor/note/other), instrument ID and valid.
- Stage 2 (registered outputs):
  - Cursor class with blink_en=1 and blink_phase=1 -> output BG entry colour (as of stage-2 cycle).
  - Note class with highlight_en=1 and instrument != active_instr -> each channel logically shifted right 1.
  - All other cases pass the stage-1 colour unchanged.
  - Cursor is never dimmed.
- Latency: exactly 2 cycles, in_valid at edge N -> out_valid at edge N+2. Throughput one pixel per cycle.
- When in_valid=0: the stage-1 valid register is 0; r/g/b still update but are don't-care while out_valid=0.
- Blink timer:
  - Counts frame_start pulses 0..BLINK_PERIOD-1.
  - On the pulse that occurs with the count at BLINK_PERIOD-1: count wraps to 0 and blink_phase toggles.
  - With blink_en=0, the counter still runs, so the phase stays frame-aligned.
  - A frame_start that coincides with in_valid affects pixels entering stage 2 from the next cycle.
- Mid-stream reset: in-flight pixels are dropped (no out_valid for them); the palette reverts to defaults.

Test Plan:
- Reset then pixel_type=6'b010000, instrument_type=1, in_valid at cycle 0 -> out_valid=1 at cycle 2 with r,g,b=00,FF,00; pixel_type=0 -> 00,00,00; 6'b100001 -> 00,FF,FF (cursor wins).
- Write pal_addr=0 with pal_data=24'h123456 while streaming instrument-0 notes -> pixel entering the same cycle reads FF0000; next pixel reads 123456. Write to pal_addr=7 -> no change to any entry.
- highlight_en=1, active_instr=2: note with instr 0 -> 7F,00,00; instr 2 -> 00,00,FF; staff pixel -> FF,FF,FF.
- BLINK_PERIOD=2, blink_en=1, continuous cursor pixels: blink_phase toggles every 2nd frame_start; cursor outputs 000000 while phase=1 and 00FFFF while phase=0.
- instrument_type=3 with NUM_INSTR=3 on a note pixel -> BG 000000.
- Assert rst_n low mid-stream with 2 pixels in flight -> out_valid drops immediately and stays 0 until new in_valid+2; palette reads defaults after release.

Source files
------------

// File: rtl/color_pipe.sv
// Two-stage pixel colour mapper: tag decode and palette lookup, then cursor blink and
// instrument dimming. Run-time-programmable palette; streaming, no backpressure.
module color_pipe #(
    parameter int unsigned NUM_INSTR    = 4,
    parameter int unsigned INSTR_W      = 2,
    parameter int unsigned CW           = 8,
    parameter int unsigned BLINK_PERIOD = 30,
    localparam int unsigned PAL_AW      = $clog2(NUM_INSTR + 3)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [5:0]          pixel_type,
    input  logic [INSTR_W-1:0]  instrument_type,
    input  logic                frame_start,
    input  logic                blink_en,
    input  logic                highlight_en,
    input  logic [INSTR_W-1:0]  active_instr,
    input  logic                pal_we,
    input  logic [PAL_AW-1:0]   pal_addr,
    input  logic [3*CW-1:0]     pal_data,
    output logic                out_valid,
    output logic [CW-1:0]       r,
    output logic [CW-1:0]       g,
    output logic [CW-1:0]       b,
    output logic                blink_phase
);

    localparam int unsigned NUM_ENT = NUM_INSTR + 3;
    localparam int unsigned CNT_W   = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

    localparam logic [PAL_AW-1:0] IDX_STAFF  = PAL_AW'(NUM_INSTR);
    localparam logic [PAL_AW-1:0] IDX_CURSOR = PAL_AW'(NUM_INSTR + 1);
    localparam logic [PAL_AW-1:0] IDX_BG     = PAL_AW'(NUM_INSTR + 2);

    localparam logic [CW-1:0] CH_F = '1;
    localparam logic [CW-1:0] CH_Z = '0;

    typedef logic [3*CW-1:0] rgb_t;
    typedef enum logic [1:0] {ClsOther, ClsNote, ClsCursor} cls_e;

    function automatic rgb_t pal_default(int unsigned idx);
        rgb_t c;
        if (idx < NUM_INSTR) begin
            case (idx % 4)
                0:       c = {CH_F, CH_Z, CH_Z};
                1:       c = {CH_Z, CH_F, CH_Z};
                2:       c = {CH_Z, CH_Z, CH_F};
                default: c = {CH_F, CH_F, CH_Z};
            endcase
        end else if (idx == NUM_INSTR) begin
            c = {CH_F, CH_F, CH_F};
        end else if (idx == NUM_INSTR + 1) begin
            c = {CH_Z, CH_F, CH_F};
        end else begin
            c = {CH_Z, CH_Z, CH_Z};
        end
        return c;
    endfunction

    // Palette
    rgb_t pal_q [NUM_ENT];
    logic pal_hit;

    assign pal_hit = (32'(pal_addr) < NUM_ENT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_ENT; i++) begin
                pal_q[i] <= pal_default(i);
            end
        end else if (pal_we && pal_hit) begin
            pal_q[pal_addr] <= pal_data;
        end
    end

    // Blink timer
    logic [CNT_W-1:0] frame_cnt_q;
    logic             blink_phase_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt_q == CNT_W'(BLINK_PERIOD - 1)) begin
                frame_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    assign blink_phase = blink_phase_q;

    // Stage 1: priority decode; an out-of-range instrument falls back to BG as a plain pixel
    logic [PAL_AW-1:0] s1_idx_d;
    cls_e              s1_cls_d;

    always_comb begin
        s1_idx_d = IDX_BG;
        s1_cls_d = ClsOther;
        if (pixel_type[5]) begin
            s1_idx_d = IDX_CURSOR;
            s1_cls_d = ClsCursor;
        end else if (pixel_type[4]) begin
            if (32'(instrument_type) < NUM_INSTR) begin
                s1_idx_d = PAL_AW'(instrument_type);
                s1_cls_d = ClsNote;
            end
        end else if (|pixel_type[3:0]) begin
            s1_idx_d = IDX_STAFF;
        end
    end

    logic               s1_valid_q;
    rgb_t               s1_rgb_q;
    cls_e               s1_cls_q;
    logic [INSTR_W-1:0] s1_instr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_rgb_q   <= '0;
            s1_cls_q   <= ClsOther;
            s1_instr_q <= '0;
        end else begin
            s1_valid_q <= in_valid;
            s1_rgb_q   <= pal_q[s1_idx_d];
            s1_cls_q   <= s1_cls_d;
            s1_instr_q <= instrument_type;
        end
    end

    // Stage 2: blink substitution and dimming
    rgb_t out_d;
    rgb_t out_q;

    always_comb begin
        out_d = s1_rgb_q;
        if (s1_cls_q == ClsCursor && blink_en && blink_phase_q) begin
            out_d = pal_q[IDX_BG];
        end else if (s1_cls_q == ClsNote && highlight_en && s1_instr_q != active_instr) begin
            out_d = {1'b0, s1_rgb_q[3*CW-1:2*CW+1],
                     1'b0, s1_rgb_q[2*CW-1:CW+1],
                     1'b0, s1_rgb_q[CW-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else begin
            out_valid <= s1_valid_q;
            out_q     <= out_d;
        end
    end

    assign r = out_q[3*CW-1:2*CW];
    assign g = out_q[2*CW-1:CW];
    assign b = out_q[CW-1:0];

endmodule

// File: tb/tb_color_pipe.sv
// Scoreboard bench for color_pipe: driver pushes expected colours from a palette/blink
// model, a negedge monitor pops and compares whenever out_valid is high.
module tb_color_pipe;

    localparam int NI = 3;
    localparam int BP = 2;
    localparam int NE = NI + 3;
    localparam int STAFF = NI;
    localparam int CURS = NI + 1;
    localparam int BG = NI + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [5:0]  pixel_type = '0;
    logic [1:0]  instrument_type = '0;
    logic        frame_start = 1'b0;
    logic        blink_en = 1'b0;
    logic        highlight_en = 1'b0;
    logic [1:0]  active_instr = '0;
    logic        pal_we = 1'b0;
    logic [2:0]  pal_addr = '0;
    logic [23:0] pal_data = '0;
    logic        out_valid;
    logic [7:0]  r, g, b;
    logic        blink_phase;

    color_pipe #(
        .NUM_INSTR   (NI),
        .INSTR_W     (2),
        .CW          (8),
        .BLINK_PERIOD(BP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .pixel_type     (pixel_type),
        .instrument_type(instrument_type),
        .frame_start    (frame_start),
        .blink_en       (blink_en),
        .highlight_en   (highlight_en),
        .active_instr   (active_instr),
        .pal_we         (pal_we),
        .pal_addr       (pal_addr),
        .pal_data       (pal_data),
        .out_valid      (out_valid),
        .r              (r),
        .g              (g),
        .b              (b),
        .blink_phase    (blink_phase)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [23:0] rgb;
        int          due;
    } exp_t;
    exp_t q[$];

    // Reference model state
    logic [23:0] mpal [NE];
    int          mcnt;
    logic        mphase;
    logic        pend_v;
    logic [23:0] pend_col;
    int          pend_cls;  // 0 other, 1 note, 2 cursor
    logic [1:0]  pend_instr;

    logic       g_be = 1'b0;
    logic       g_he = 1'b0;
    logic [1:0] g_ai = '0;

    function automatic logic [23:0] def_col(int i);
        if (i < NI) begin
            case (i % 4)
                0: return 24'hFF0000;
                1: return 24'h00FF00;
                2: return 24'h0000FF;
                default: return 24'hFFFF00;
            endcase
        end
        if (i == STAFF) return 24'hFFFFFF;
        if (i == CURS) return 24'h00FFFF;
        return 24'h000000;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NE; i++) mpal[i] = def_col(i);
        mcnt = 0;
        mphase = 1'b0;
        pend_v = 1'b0;
        q.delete();
    endtask

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock of stimulus; the model retires the previous pixel and takes in the new one
    task automatic cycle(input logic v, input logic [5:0] pt, input logic [1:0] it,
                         input logic fs, input logic be, input logic he, input logic [1:0] ai,
                         input logic we, input logic [2:0] pa, input logic [23:0] pd);
        logic [23:0] col;
        @(posedge clk);
        #1;
        if (rst_n) check("blink_phase", {23'd0, blink_phase}, {23'd0, mphase});
        in_valid = v; pixel_type = pt; instrument_type = it; frame_start = fs;
        blink_en = be; highlight_en = he; active_instr = ai;
        pal_we = we; pal_addr = pa; pal_data = pd;
        if (pend_v) begin
            col = pend_col;
            if (pend_cls == 2 && be && mphase) col = mpal[BG];
            else if (pend_cls == 1 && he && pend_instr != ai)
                col = {pend_col[23:16] >> 1, pend_col[15:8] >> 1, pend_col[7:0] >> 1};
            q.push_back('{rgb: col, due: cyc + 1});
        end
        pend_v = v;
        if (v) begin
            pend_instr = it;
            if (pt[5]) begin
                pend_col = mpal[CURS]; pend_cls = 2;
            end else if (pt[4] && int'(it) < NI) begin
                pend_col = mpal[it]; pend_cls = 1;
            end else if (pt[4] || pt[3:0] == 4'd0) begin
                pend_col = mpal[BG]; pend_cls = 0;
            end else begin
                pend_col = mpal[STAFF]; pend_cls = 0;
            end
        end
        if (we && int'(pa) < NE) mpal[pa] = pd;
        if (fs) begin
            if (mcnt == BP - 1) begin
                mcnt = 0;
                mphase = ~mphase;
            end else begin
                mcnt++;
            end
        end
    endtask

    task automatic px(input logic [5:0] pt, input logic [1:0] it);
        cycle(1'b1, pt, it, 1'b0, g_be, g_he, g_ai, 1'b0, 3'd0, 24'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 6'd0, 2'd0, 1'b0, g_be, g_he, g_ai, 1'b0, 3'd0, 24'd0);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0; pal_we = 1'b0; frame_start = 1'b0;
        model_reset();
        #1;
        check("reset out_valid", {23'd0, out_valid}, 24'd0);
        check("reset rgb", {r, g, b}, 24'd0);
        check("reset blink_phase", {23'd0, blink_phase}, 24'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compares colour and arrival cycle of every valid output
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected out_valid: got rgb %h at cycle %0d, expected none",
                             {r, g, b}, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (e.due != cyc || {r, g, b} !== e.rgb) begin
                        failures++;
                        $display("FAIL pixel: got %h at cycle %0d expected %h at cycle %0d",
                                 {r, g, b}, cyc, e.rgb, e.due);
                    end
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                exp_t e;
                checks++;
                failures++;
                e = q.pop_front();
                $display("FAIL missing pixel: got no out_valid at cycle %0d expected %h",
                         cyc, e.rgb);
            end
        end
    end

    initial begin
        model_reset();
        apply_reset();

        // Basic decode: green note, background, cursor beats staff
        px(6'b010000, 2'd1);
        px(6'b000000, 2'd0);
        px(6'b100001, 2'd0);
        px(6'b000100, 2'd0);
        idle(3);

        // Palette write while streaming instrument-0 notes; out-of-range writes ignored
        px(6'b010000, 2'd0);
        cycle(1'b1, 6'b010000, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 3'd0, 24'h123456);
        px(6'b010000, 2'd0);
        cycle(1'b1, 6'b010000, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 3'd7, 24'hABCDEF);
        cycle(1'b1, 6'b000000, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 3'd6, 24'h777777);
        px(6'b000000, 2'd0);
        px(6'b010000, 2'd0);
        idle(3);

        // Highlight: instrument 2 stays bright, others halved, staff untouched
        g_he = 1'b1; g_ai = 2'd2;
        px(6'b010000, 2'd0);
        px(6'b010000, 2'd2);
        px(6'b001000, 2'd0);
        px(6'b010000, 2'd1);
        px(6'b110000, 2'd1);
        px(6'b010000, 2'd3);
        g_he = 1'b0;
        idle(3);

        // Blink with a non-black BG so hidden cursors are distinguishable
        cycle(1'b0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 3'(BG), 24'h0A0B0C);
        g_be = 1'b1;
        for (int i = 0; i < 60; i++)
            cycle(1'b1, 6'b100000, 2'd0, (i % 3) == 0, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 24'd0);
        g_be = 1'b0;
        idle(3);

        // Out-of-range instrument maps to BG
        px(6'b010000, 2'd3);
        idle(3);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            logic [5:0] pt;
            pt = 6'($urandom);
            if ($urandom_range(0, 2) == 0) pt[5] = 1'b0;
            cycle($urandom_range(0, 3) != 0, pt, 2'($urandom), $urandom_range(0, 3) == 0,
                  1'($urandom), 1'($urandom), 2'($urandom), $urandom_range(0, 9) == 0,
                  3'($urandom), 24'($urandom));
        end
        idle(3);

        // Mid-stream reset with pixels in flight, then defaults must be back
        px(6'b010000, 2'd0);
        px(6'b010000, 2'd1);
        apply_reset();
        idle(2);
        px(6'b010000, 2'd0);
        px(6'b010000, 2'd1);
        px(6'b000001, 2'd0);
        px(6'b100000, 2'd0);
        px(6'b000000, 2'd0);
        idle(4);

        check("scoreboard drained", 24'(q.size()), 24'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish by 200000 expected earlier");
        $fatal(1, "timeout");
    end

endmodule
